compare_9_8_7_const_10: RTL and testbench

Compares an RNS-encoded unsigned integer X, with moduli 7, 8 and 9 and range 0..503, against the fixed constant 10.
It produces one-hot less/equal/greater flags, and the result is registered.
The block sits on the output side of the RNS datapath and feeds threshold decisions without a full reverse-conversion pipeline elsewhere.

---
 rtl/rns_9_8_7_pkg.sv | 36 +++
 rtl/rns_to_bin_9_8_7.sv | 51 +++++
 rtl/compare_9_8_7_const_10.sv | 63 ++++++
 tb/tb_compare_9_8_7_const_10.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rns_9_8_7_pkg.sv
// rns_9_8_7_pkg
// Shared constants for the {7, 8, 9} residue number system datapath.
// It holds the moduli, the dynamic range, the CRT reconstruction weights,
// the residue widths, the comparison constant and the packed flag type
// used by the threshold comparator.
package rns_9_8_7_pkg;

    // Moduli and dynamic range (M = 7 * 8 * 9)
    localparam int unsigned M1 = 7;
    localparam int unsigned M2 = 8;
    localparam int unsigned M3 = 9;
    localparam int unsigned M  = M1 * M2 * M3;

    // Residue and result widths
    localparam int unsigned X1_W  = 3;
    localparam int unsigned X2_W  = 3;
    localparam int unsigned X3_W  = 4;
    localparam int unsigned BIN_W = 9;
    localparam int unsigned SUM_W = 13;

    // CRT weights: each is 1 modulo its own modulus and 0 modulo the others
    localparam int unsigned W1 = 288;
    localparam int unsigned W2 = 441;
    localparam int unsigned W3 = 280;

    // Fixed threshold the comparator tests against
    localparam logic [BIN_W-1:0] CMP_CONST = 9'd10;

    // Registered comparison result, one-hot for legal inputs, all-zero if invalid
    typedef struct packed {
        logic le;
        logic eq;
        logic gr;
    } cmp_flags_t;

endpackage

// File: rtl/rns_to_bin_9_8_7.sv
// rns_to_bin_9_8_7
// Purely combinational reverse converter from {7, 8, 9} residues to a 9-bit
// unsigned binary value using the Chinese Remainder Theorem.
// Ports:
//   x1      in  3  residue mod 7 (legal 0..6)
//   x2      in  3  residue mod 8 (legal 0..7)
//   x3      in  4  residue mod 9 (legal 0..8)
//   x       out 9  reconstructed value 0..503 (don't care when invalid)
//   invalid out 1  high when x1 or x3 holds an out-of-range residue
module rns_to_bin_9_8_7
    import rns_9_8_7_pkg::*;
(
    input  logic [X1_W-1:0]  x1,
    input  logic [X2_W-1:0]  x2,
    input  logic [X3_W-1:0]  x3,
    output logic [BIN_W-1:0] x,
    output logic             invalid
);

    localparam logic [SUM_W-1:0] W1_S = SUM_W'(W1);
    localparam logic [SUM_W-1:0] W2_S = SUM_W'(W2);
    localparam logic [SUM_W-1:0] W3_S = SUM_W'(W3);

    // Multiples of M used by the restoring reduction below
    localparam logic [SUM_W-1:0] M_X8 = SUM_W'(8 * M);
    localparam logic [SUM_W-1:0] M_X4 = SUM_W'(4 * M);
    localparam logic [SUM_W-1:0] M_X2 = SUM_W'(2 * M);
    localparam logic [SUM_W-1:0] M_X1 = SUM_W'(M);

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rem;

    // The weighted sum tops out at 7055 < 14 * 504, so the quotient fits in
    // four bits and a four-step restoring subtraction (8M, 4M, 2M, M) leaves
    // exactly sum mod 504 without a general divider.
    always_comb begin
        sum = W1_S * SUM_W'(x1) + W2_S * SUM_W'(x2) + W3_S * SUM_W'(x3);
        rem = sum;
        if (rem >= M_X8) rem = rem - M_X8;
        if (rem >= M_X4) rem = rem - M_X4;
        if (rem >= M_X2) rem = rem - M_X2;
        if (rem >= M_X1) rem = rem - M_X1;
        x = rem[BIN_W-1:0];
    end

    // x2 spans its full 3-bit range, so only x1 and x3 can be illegal
    always_comb begin
        invalid = (x1 >= X1_W'(M1)) || (x3 >= X3_W'(M3));
    end

endmodule

// File: rtl/compare_9_8_7_const_10.sv
// compare_9_8_7_const_10
// Compares an RNS-encoded unsigned value X (moduli 7, 8, 9; range 0..503)
// against the constant 10 and registers one-hot less/equal/greater flags.
// Ports:
//   clk  in  1  system clock, rising edge
//   rst  in  1  asynchronous active-high reset, clears all flags
//   x1   in  3  residue X mod 7
//   x2   in  3  residue X mod 8
//   x3   in  4  residue X mod 9
//   le   out 1  X < 10   (registered)
//   eq   out 1  X == 10  (registered)
//   gr   out 1  X > 10   (registered)
// Illegal residues register as all-zero flags.
module compare_9_8_7_const_10
    import rns_9_8_7_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [X1_W-1:0] x1,
    input  logic [X2_W-1:0] x2,
    input  logic [X3_W-1:0] x3,
    output logic            le,
    output logic            eq,
    output logic            gr
);

    logic [BIN_W-1:0] x_bin;
    logic             invalid;
    cmp_flags_t       flags_next;
    cmp_flags_t       flags_q;

    rns_to_bin_9_8_7 u_rns_to_bin (
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .x       (x_bin),
        .invalid (invalid)
    );

    // Unsigned 9-bit compare; an invalid input suppresses every flag so that
    // downstream logic can recognise all-zero as "no decision"
    always_comb begin
        flags_next = '0;
        if (!invalid) begin
            flags_next.le = (x_bin <  CMP_CONST);
            flags_next.eq = (x_bin == CMP_CONST);
            flags_next.gr = (x_bin >  CMP_CONST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_next;
        end
    end

    assign le = flags_q.le;
    assign eq = flags_q.eq;
    assign gr = flags_q.gr;

endmodule

// File: tb/tb_compare_9_8_7_const_10.sv
// tb_compare_9_8_7_const_10
// Directed bench for the RNS threshold comparator. Expected flags are derived
// from the integer X the bench chose, pushed to a scoreboard when the
// residues are driven and popped one edge later when the DUT result is due.
module tb_compare_9_8_7_const_10;

    logic       clk;
    logic       rst;
    logic [2:0] x1;
    logic [2:0] x2;
    logic [3:0] x3;
    logic       le;
    logic       eq;
    logic       gr;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    compare_9_8_7_const_10 dut (
        .clk (clk),
        .rst (rst),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .le  (le),
        .eq  (eq),
        .gr  (gr)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference flags {le, eq, gr} for an integer value in 0..503
    function automatic logic [2:0] expFlags(input int v);
        return {v < 10, v == 10, v > 10};
    endfunction

    task automatic compareFlags(input logic [2:0] expv, input string tag);
        logic [2:0] obs;
        obs = {le, eq, gr};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed le/eq/gr=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkOneHot(input string tag);
        int ones;
        ones = $countones({le, eq, gr});
        total++;
        assert (ones === 1) else begin
            bad++;
            $error("[TB] FAIL %s_onehot: observed %0d flags high expected 1", tag, ones);
        end
    endtask

    // Drive residues between edges and queue what should appear after the next edge
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                                 input logic [3:0] c, input logic [2:0] expv,
                                 input string tag);
        x1 = a;
        x2 = b;
        x3 = c;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
    endtask

    // Wait for the sampling edge, then compare one step off the edge
    task automatic checkOutput(input logic want_onehot);
        logic [2:0] expv;
        string      tag;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_empty: observed no entry expected one");
        end else begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            compareFlags(expv, tag);
            if (want_onehot) checkOneHot(tag);
        end
    endtask

    task automatic applyValue(input int v, input string tag);
        applyStimulus(3'(v % 7), 3'(v % 8), 4'(v % 9), expFlags(v), tag);
    endtask

    initial begin
        // Asynchronous reset with arbitrary inputs, before any clock edge
        rst = 1'b1;
        x1  = 3'd5;
        x2  = 3'd6;
        x3  = 4'd7;
        #2;
        compareFlags(3'b000, "reset_async");

        // Release reset and show the first edge samples the current inputs
        #1;
        rst = 1'b0;
        applyStimulus(3'd3, 3'd2, 4'd1, 3'b010, "post_reset_eq");
        checkOutput(1'b1);

        // Neighbours of the constant, back to back
        applyStimulus(3'd2, 3'd1, 4'd0, 3'b100, "x9_le");
        checkOutput(1'b1);
        applyStimulus(3'd3, 3'd2, 4'd1, 3'b010, "x10_eq");
        checkOutput(1'b1);
        applyStimulus(3'd4, 3'd3, 4'd2, 3'b001, "x11_gr");
        checkOutput(1'b1);

        // Range extremes
        applyStimulus(3'd0, 3'd0, 4'd0, 3'b100, "x0_le");
        checkOutput(1'b1);
        applyStimulus(3'd6, 3'd7, 4'd8, 3'b001, "x503_gr");
        checkOutput(1'b1);

        // Illegal residues, then recovery with a legal value
        applyStimulus(3'd7, 3'd0, 4'd0,  3'b000, "illegal_x1");
        checkOutput(1'b0);
        applyStimulus(3'd0, 3'd0, 4'd12, 3'b000, "illegal_x3");
        checkOutput(1'b0);
        applyStimulus(3'd3, 3'd2, 4'd1,  3'b010, "legal_after_illegal");
        checkOutput(1'b1);

        // Full sweep with a half-cycle reset pulse while i = 200 is on the inputs
        for (int i = 0; i < 504; i++) begin
            applyValue(i, $sformatf("sweep_%0d", i));
            if (i == 200) begin
                rst = 1'b1;
                #1;
                compareFlags(3'b000, "midreset_async");
                #3;
                rst = 1'b0;
                #1;
                compareFlags(3'b000, "midreset_hold");
            end
            checkOutput(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no completion expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
